mio_bus_ctrl: RTL
=================

// Module: mio_bus_ctrl
// PURPOSE
//  Data-side bus controller directly downstream of SCPU's memory port.
//  Consumes CPU_MIO/MemRW/Addr_out/Data_out; produces MIO_ready/Data_in.
//  Inserts a fixed number of wait states and decodes word RAM plus three memory-mapped I/O registers.
//  Replaces the bench's constant MIO_ready=1 with a real stall handshake.
// PARAMETERS
//  WAIT_CYCLES  2   extra wait cycles per access, legal 0..15
//  ADDR_W       10  RAM word-index width; RAM = 2**ADDR_W x 32 bit
//  SW_W         16  switch input width
//  LED_W        16  LED register width
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      reset, synchronous, active-low
//  cpu_mio     in   1      access request (SCPU CPU_MIO), held until mio_ready
//  cpu_mem_rw  in   1      1 = write, 0 = read (SCPU MemRW)
//  cpu_addr    in   32     byte address (SCPU Addr_out)
//  cpu_wdata   in   32     write data (SCPU Data_out)
//  mio_ready   out  1      1-cycle completion pulse (to SCPU MIO_ready)
//  cpu_rdata   out  32     read data (to SCPU Data_in)
//  sw_in       in   SW_W   switch inputs
//  led_out     out  LED_W  LED register
//  bus_err     out  1      error pulse; present only with MIO_ERR_EN
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE; mio_ready=0; cpu_rdata=0; led_out=0; cycle counter=0; bus_err=0. RAM is not cleared.
//  Map: 0x0000_0000..(4*2**ADDR_W-1) RAM, index cpu_addr[ADDR_W+1:2].
//       0xF000_0000 LED reg (R/W, low LED_W bits, reads zero-extended).
//       0xF000_0004 switches (RO, zero-extended; writes ignored).
//       0xF000_0008 cycle counter (R; any write clears it).
//  Unmapped: reads return 0; writes are dropped.
//  FSM IDLE -> WAIT -> DONE -> IDLE:
//   IDLE: at an edge with cpu_mio=1, latch addr/wdata/rw and load cnt=WAIT_CYCLES.
//     Go to WAIT, or to DONE if WAIT_CYCLES==0.
//   WAIT: cnt decrements each edge; at an edge with cnt==1 go to DONE.
//     Any WAIT_CYCLES>=1 gives exactly WAIT_CYCLES WAIT cycles.
//   The edge entering DONE commits a write, or registers read data into cpu_rdata.
//   DONE: mio_ready=1 for exactly this cycle; unconditional return to IDLE.
//  Latency: request sampled at edge N -> mio_ready high in the cycle after edge N+WAIT_CYCLES.
//   WAIT_CYCLES=0 -> 1 cycle.
//  Output stability: mio_ready=0 in IDLE and WAIT. cpu_rdata holds until the next read completes; writes leave it unchanged.
//  Bus inputs are ignored outside IDLE; the latched copies are used for the whole access.
//  cpu_mio still high in DONE: treated as a new request and sampled in the following IDLE.
//   Back-to-back accesses therefore take WAIT_CYCLES+2 cycles each.
//  Counter: 32-bit, +1 every cycle, wraps 0xFFFF_FFFF->0. A write commit clears it to 0 (clear wins over increment).
//   Read value is the counter at the edge entering DONE.
//  rst low mid-access: access aborts; a pending write is never committed; mio_ready stays 0.
//  Address bits [1:0] are ignored (word access) unless MIO_ERR_EN.
// CONFIGURATION
//  MIO_ERR_EN defined: bus_err port exists.
//   A misaligned (addr[1:0]!=0) or unmapped access completes normally: mio_ready pulses, bus_err=1 in the same cycle.
//   Its write is suppressed; a read returns cpu_rdata=0.
//  MIO_ERR_EN undefined: no bus_err port. Misaligned addresses are truncated to the word; unmapped accesses behave as above.
// TESTING
//  T1 WAIT_CYCLES=2: write 0x1234_5678 @0x10, then read 0x10.
//     -> each mio_ready pulse arrives 3 cycles after its request; cpu_rdata=0x1234_5678.
//  T2 write 0x0000_A5A5 @0xF000_0000 -> led_out=0xA5A5 from the DONE cycle; read back = 0x0000_A5A5.
//  T3 sw_in=0x00FF; write 0xFFFF @0xF000_0004, then read -> 0x0000_00FF.
//  T4 write @0xF000_0008, then read with cpu_mio held high.
//     -> value = cycles from the clear edge to the read's DONE edge (WAIT_CYCLES+2).
//  T5 rst low during WAIT of a write 0xCAFE @0x20 -> mio_ready never pulses; RAM[8] keeps its old value.
//  T6 MIO_ERR_EN: read 0x0000_0006 and read 0x8000_0000.
//     -> each returns bus_err=1 with mio_ready and cpu_rdata=0; a write to 0x8000_0000 changes nothing.

Source files
------------

// File: rtl/mio_bus_ctrl_if.sv
// mio_bus_if: SCPU data-port request/ready bundle between CPU (master) and bus controller (slave)
interface mio_bus_if;
  logic cpu_mio, cpu_mem_rw, mio_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  modport master (output cpu_mio, cpu_mem_rw, cpu_addr, cpu_wdata, input mio_ready, cpu_rdata);
  modport slave (input cpu_mio, cpu_mem_rw, cpu_addr, cpu_wdata, output mio_ready, cpu_rdata);
endinterface

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: wait-state data bus controller with word RAM, LED/switch/cycle-counter registers
// Define MIO_ERR_EN to add the bus_err port and reject misaligned/unmapped accesses.
module mio_bus_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W = 10,
  parameter int SW_W = 16,
  parameter int LED_W = 16
) (
  input  logic clk,
  input  logic rst,
  mio_bus_if.slave bus,
  input  logic [SW_W-1:0] sw_in,
  output logic [LED_W-1:0] led_out
`ifdef MIO_ERR_EN
  , output logic bus_err
`endif
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [31:0] a_q, d_q, a_c, d_c, w_a, cyc, rdata, rd;
  logic rw_q, rw_c, idle_go, commit, is_ram, is_led, is_sw, is_cyc, err, we;
  logic [31:0] ram [2**ADDR_W];
  // In IDLE the live bus is the access; afterwards the latched copy is.
  assign idle_go = state == IDLE && bus.cpu_mio;
  assign commit = (idle_go && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
  assign a_c = state == IDLE ? bus.cpu_addr : a_q;
  assign d_c = state == IDLE ? bus.cpu_wdata : d_q;
  assign rw_c = state == IDLE ? bus.cpu_mem_rw : rw_q;
  assign w_a = a_c & ~32'd3;
  assign is_ram = (w_a >> (ADDR_W + 2)) == 32'd0;
  assign is_led = w_a == 32'hF000_0000;
  assign is_sw = w_a == 32'hF000_0004;
  assign is_cyc = w_a == 32'hF000_0008;
`ifdef MIO_ERR_EN
  assign err = a_c[1:0] != 2'b00 || !(is_ram || is_led || is_sw || is_cyc);
  assign bus_err = state == DONE && err;
`else
  assign err = 1'b0;
`endif
  assign we = commit && rw_c && !err;
  // Counter reads return the value it takes at the commit edge.
  assign rd = err ? 32'd0 : is_ram ? ram[a_c[ADDR_W+1:2]] : is_led ? 32'(led_out) :
              is_sw ? 32'(sw_in) : is_cyc ? cyc + 32'd1 : 32'd0;
  assign bus.mio_ready = state == DONE;
  assign bus.cpu_rdata = rdata;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      cyc <= '0;
      rdata <= '0;
      led_out <= '0;
    end else begin
      state <= commit ? DONE : idle_go ? WAIT : state[1] ? IDLE : state;
      cnt <= idle_go ? 4'(WAIT_CYCLES) : state == WAIT ? cnt - 4'd1 : cnt;
      cyc <= (we && is_cyc) ? 32'd0 : cyc + 32'd1;
      if (commit && !rw_c) rdata <= rd;
      if (we && is_led) led_out <= d_c[LED_W-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (idle_go) begin
      a_q <= bus.cpu_addr;
      d_q <= bus.cpu_wdata;
      rw_q <= bus.cpu_mem_rw;
    end
    if (rst && we && is_ram) ram[a_c[ADDR_W+1:2]] <= d_c;
  end
endmodule
